// File: rtl/cpu_mc_control_pkg.sv
// Shared encodings for the multi-cycle control unit: states, opcodes,
// writeback/PC-source selects and the decoded control bundle.
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_BRANCH = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  localparam logic [3:0] OP_ADD    = 4'h0;
  localparam logic [3:0] OP_SUB    = 4'h1;
  localparam logic [3:0] OP_XOR    = 4'h2;
  localparam logic [3:0] OP_RED    = 4'h3;
  localparam logic [3:0] OP_SLL    = 4'h4;
  localparam logic [3:0] OP_SRA    = 4'h5;
  localparam logic [3:0] OP_ROR    = 4'h6;
  localparam logic [3:0] OP_PADDSB = 4'h7;
  localparam logic [3:0] OP_LW     = 4'h8;
  localparam logic [3:0] OP_SW     = 4'h9;
  localparam logic [3:0] OP_LLB    = 4'hA;
  localparam logic [3:0] OP_LHB    = 4'hB;
  localparam logic [3:0] OP_B      = 4'hC;
  localparam logic [3:0] OP_BR     = 4'hD;
  localparam logic [3:0] OP_PCS    = 4'hE;
  localparam logic [3:0] OP_HLT    = 4'hF;

  localparam logic [1:0] MTR_PC  = 2'b00;
  localparam logic [1:0] MTR_IMM = 2'b01;
  localparam logic [1:0] MTR_ALU = 2'b10;
  localparam logic [1:0] MTR_MEM = 2'b11;

  localparam logic [1:0] PCS_NEXT = 2'b00;
  localparam logic [1:0] PCS_REG  = 2'b01;
  localparam logic [1:0] PCS_IMM  = 2'b11;

  typedef struct packed {
    logic       imem_req;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_sour;
    logic       reg_read;
    logic [2:0] alu_op;
    logic       alu_src;
    logic       mem_read;
    logic       mem_write;
    logic [1:0] mem_to_reg;
    logic       reg_write;
    logic       lh;
    logic       hlt;
  } ctrl_t;

endpackage

// File: rtl/cpu_mc_control_outdec.sv
// Combinational decode of (state, opcode) into the datapath control bundle.
// Only FETCH (ack) and BRANCH (br_taken) look at live inputs.
module cpu_mc_outdec
  import cpu_ctrl_pkg::*;
(
  input  state_t     i_state,
  input  logic [3:0] i_op,
  input  logic       i_legal,
  input  logic       i_imem_ack,
  input  logic       i_br_taken,
  output ctrl_t      o_ctrl
);

  always_comb begin
    o_ctrl = '0;
    case (i_state)
      S_FETCH: begin
        o_ctrl.imem_req = 1'b1;
        o_ctrl.ir_write = i_imem_ack;
        o_ctrl.pc_write = i_imem_ack;
        o_ctrl.pc_sour  = PCS_NEXT;
      end
      S_DECODE: o_ctrl.reg_read = i_legal && (i_op <= OP_SW || i_op == OP_BR);
      S_EXEC, S_MEM: begin
        // MEM keeps the address computation stable while waiting for the ack
        o_ctrl.alu_op  = i_op[3] ? 3'b000 : i_op[2:0];
        o_ctrl.alu_src = (i_op >= OP_SLL && i_op <= OP_ROR) || i_op == OP_LW || i_op == OP_SW;
        if (i_state == S_MEM) begin
          o_ctrl.mem_read  = (i_op == OP_LW);
          o_ctrl.mem_write = (i_op == OP_SW);
        end
      end
      S_WB: begin
        o_ctrl.reg_write = 1'b1;
        o_ctrl.lh        = (i_op == OP_LHB);
        case (i_op)
          OP_LW:          o_ctrl.mem_to_reg = MTR_MEM;
          OP_LLB, OP_LHB: o_ctrl.mem_to_reg = MTR_IMM;
          OP_PCS:         o_ctrl.mem_to_reg = MTR_PC;
          default:        o_ctrl.mem_to_reg = MTR_ALU;
        endcase
      end
      S_BRANCH: begin
        o_ctrl.pc_sour  = (i_op == OP_B) ? PCS_IMM : PCS_REG;
        o_ctrl.pc_write = i_br_taken;
      end
      S_HALT:  o_ctrl.hlt = 1'b1;
      default: o_ctrl = '0;
    endcase
  end

endmodule

// File: rtl/cpu_mc_control.sv
// Multi-cycle control FSM with memory wait handling and optional timeout.
// Define CPU_MC_CONTROL_PERF_EN to add cycle/instruction counters.
module cpu_mc_control
  import cpu_ctrl_pkg::*;
#(
  parameter int OPC_W       = 4,
  parameter int ALUOP_W     = 3,
  parameter int MEM_TIMEOUT = 0,
  parameter int CNT_W       = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [OPC_W-1:0]   opcode,
  input  logic               br_taken,
  input  logic               imem_ack,
  input  logic               dmem_ack,
  output logic               imem_req,
  output logic               IRWrite,
  output logic               PCWrite,
  output logic [1:0]         PCSour,
  output logic               RegRead,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic               ALUsrc,
  output logic               MemRead,
  output logic               MemWrite,
  output logic [1:0]         MemtoReg,
  output logic               RegWrite,
  output logic               LH,
  output logic               HLT,
  output logic               illegal_op,
  output logic               mem_timeout,
  output logic [2:0]         state
`ifdef CPU_MC_CONTROL_PERF_EN
  ,
  output logic [CNT_W-1:0]   cyc_cnt,
  output logic [CNT_W-1:0]   instr_cnt
`endif
);

  localparam logic [31:0] WAIT_LIM = (MEM_TIMEOUT > 0) ? 32'(MEM_TIMEOUT - 1) : 32'd0;

  state_t      r_state, w_next;
  logic [3:0]  r_opq;
  logic        r_ill, r_to;
  logic [31:0] r_wait;
  logic        w_upper_nz, w_pending, w_ack, w_to_hit;
  logic [3:0]  w_op;
  ctrl_t       w_ctrl, w_oc;

  assign w_upper_nz = |(opcode >> 4);
  assign w_pending  = (r_state == S_FETCH) || (r_state == S_MEM);
  assign w_ack      = (r_state == S_FETCH) ? imem_ack : dmem_ack;
  // An ack in the limit cycle still completes the access
  assign w_to_hit   = (MEM_TIMEOUT > 0) && w_pending && !w_ack && (r_wait == WAIT_LIM);
  assign w_op       = (r_state == S_DECODE) ? opcode[3:0] : r_opq;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:  if (imem_ack) w_next = S_DECODE; else if (w_to_hit) w_next = S_HALT;
      S_DECODE: begin
        if (w_upper_nz) w_next = S_HALT;
        else case (opcode[3:0])
          OP_HLT:                 w_next = S_HALT;
          OP_B, OP_BR:            w_next = S_BRANCH;
          OP_LLB, OP_LHB, OP_PCS: w_next = S_WB;
          default:                w_next = S_EXEC;
        endcase
      end
      S_EXEC:   w_next = (r_opq == OP_LW || r_opq == OP_SW) ? S_MEM : S_WB;
      S_MEM: begin
        if (dmem_ack)      w_next = (r_opq == OP_LW) ? S_WB : S_FETCH;
        else if (w_to_hit) w_next = S_HALT;
      end
      S_WB, S_BRANCH: w_next = S_FETCH;
      S_HALT:   w_next = S_HALT;
      default:  w_next = S_HALT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_FETCH;
      r_opq   <= '0;
      r_ill   <= 1'b0;
      r_to    <= 1'b0;
      r_wait  <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) begin
        r_opq <= opcode[3:0];
        if (w_upper_nz) r_ill <= 1'b1;
      end
      if (w_to_hit) r_to <= 1'b1;
      r_wait <= (w_pending && !w_ack) ? r_wait + 32'd1 : 32'd0;
    end
  end

  cpu_mc_outdec u_outdec (
    .i_state    (r_state),
    .i_op       (w_op),
    .i_legal    (!w_upper_nz),
    .i_imem_ack (imem_ack),
    .i_br_taken (br_taken),
    .o_ctrl     (w_ctrl)
  );

  // Reset forces every output low in the same cycle, aborting any access
  assign w_oc        = rst ? '0 : w_ctrl;
  assign imem_req    = w_oc.imem_req;
  assign IRWrite     = w_oc.ir_write;
  assign PCWrite     = w_oc.pc_write;
  assign PCSour      = w_oc.pc_sour;
  assign RegRead     = w_oc.reg_read;
  assign ALUOp       = ALUOP_W'(w_oc.alu_op);
  assign ALUsrc      = w_oc.alu_src;
  assign MemRead     = w_oc.mem_read;
  assign MemWrite    = w_oc.mem_write;
  assign MemtoReg    = w_oc.mem_to_reg;
  assign RegWrite    = w_oc.reg_write;
  assign LH          = w_oc.lh;
  assign HLT         = w_oc.hlt;
  assign illegal_op  = r_ill & ~rst;
  assign mem_timeout = r_to & ~rst;
  assign state       = rst ? 3'd0 : r_state;

`ifdef CPU_MC_CONTROL_PERF_EN
  logic [CNT_W-1:0] r_cyc, r_instr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cyc   <= '0;
      r_instr <= '0;
    end else begin
      if (r_state != S_HALT) r_cyc <= r_cyc + 1'b1;
      if (w_next == S_FETCH &&
          (r_state == S_WB || r_state == S_MEM || r_state == S_BRANCH))
        r_instr <= r_instr + 1'b1;
    end
  end

  assign cyc_cnt   = rst ? '0 : r_cyc;
  assign instr_cnt = rst ? '0 : r_instr;
`else
  // Keeps CNT_W referenced when the counters are compiled out
  logic [CNT_W-1:0] w_unused_cnt;
  assign w_unused_cnt = '0;
`endif

endmodule

// File: tb/tb_cpu_mc_control.sv
// Directed bench: default-parameter DUT for the instruction flows, plus a
// MEM_TIMEOUT=4 / OPC_W=6 DUT for timeout and illegal-opcode handling.
module tb_cpu_mc_control;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // DUT A: defaults
  logic       rst, br_taken, imem_ack, dmem_ack;
  logic [3:0] opcode;
  logic       imem_req, IRWrite, PCWrite, RegRead, ALUsrc, MemRead, MemWrite, RegWrite, LH, HLT;
  logic       illegal_op, mem_timeout;
  logic [1:0] PCSour, MemtoReg;
  logic [2:0] ALUOp, state;
`ifdef CPU_MC_CONTROL_PERF_EN
  logic [31:0] cyc_cnt, instr_cnt, b_cyc_cnt, b_instr_cnt;
`endif

  // DUT B: timeout + wide opcode
  logic       b_rst, b_br_taken, b_imem_ack, b_dmem_ack;
  logic [5:0] b_opcode;
  logic       b_imem_req, b_IRWrite, b_PCWrite, b_RegRead, b_ALUsrc, b_MemRead, b_MemWrite;
  logic       b_RegWrite, b_LH, b_HLT, b_illegal_op, b_mem_timeout;
  logic [1:0] b_PCSour, b_MemtoReg;
  logic [2:0] b_ALUOp, b_state;

  cpu_mc_control dut_a (
    .clk(clk), .rst(rst), .opcode(opcode), .br_taken(br_taken),
    .imem_ack(imem_ack), .dmem_ack(dmem_ack), .imem_req(imem_req),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .PCSour(PCSour), .RegRead(RegRead),
    .ALUOp(ALUOp), .ALUsrc(ALUsrc), .MemRead(MemRead), .MemWrite(MemWrite),
    .MemtoReg(MemtoReg), .RegWrite(RegWrite), .LH(LH), .HLT(HLT),
    .illegal_op(illegal_op), .mem_timeout(mem_timeout), .state(state)
`ifdef CPU_MC_CONTROL_PERF_EN
    , .cyc_cnt(cyc_cnt), .instr_cnt(instr_cnt)
`endif
  );

  cpu_mc_control #(.OPC_W(6), .MEM_TIMEOUT(4)) dut_b (
    .clk(clk), .rst(b_rst), .opcode(b_opcode), .br_taken(b_br_taken),
    .imem_ack(b_imem_ack), .dmem_ack(b_dmem_ack), .imem_req(b_imem_req),
    .IRWrite(b_IRWrite), .PCWrite(b_PCWrite), .PCSour(b_PCSour), .RegRead(b_RegRead),
    .ALUOp(b_ALUOp), .ALUsrc(b_ALUsrc), .MemRead(b_MemRead), .MemWrite(b_MemWrite),
    .MemtoReg(b_MemtoReg), .RegWrite(b_RegWrite), .LH(b_LH), .HLT(b_HLT),
    .illegal_op(b_illegal_op), .mem_timeout(b_mem_timeout), .state(b_state)
`ifdef CPU_MC_CONTROL_PERF_EN
    , .cyc_cnt(b_cyc_cnt), .instr_cnt(b_instr_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1; opcode = 4'h0; br_taken = 0; imem_ack = 0; dmem_ack = 0;
    b_rst = 1; b_opcode = 6'h0; b_br_taken = 0; b_imem_ack = 0; b_dmem_ack = 0;
    step(); step();
    chk("rst_state", 32'(state), 0);
    chk("rst_req", 32'(imem_req), 0);
    chk("rst_hlt", 32'(HLT), 0);
    chk("rst_ill", 32'(illegal_op), 0);

    // ADD, zero-wait
    rst = 0; imem_ack = 1; dmem_ack = 1; opcode = 4'h0; #1;
    chk("add_c0_req", 32'(imem_req), 1);
    chk("add_c0_irw", 32'(IRWrite), 1);
    chk("add_c0_pcw", 32'(PCWrite), 1);
    chk("add_c0_pcs", 32'(PCSour), 0);
    step();
    chk("add_c1_state", 32'(state), 1);
    chk("add_c1_rr", 32'(RegRead), 1);
    chk("add_c1_pcw", 32'(PCWrite), 0);
    step();
    chk("add_c2_state", 32'(state), 2);
    chk("add_c2_aluop", 32'(ALUOp), 0);
    chk("add_c2_alusrc", 32'(ALUsrc), 0);
    step();
    chk("add_c3_state", 32'(state), 4);
    chk("add_c3_rw", 32'(RegWrite), 1);
    chk("add_c3_mtr", 32'(MemtoReg), 2);
    step();
    chk("add_c4_state", 32'(state), 0);
`ifdef CPU_MC_CONTROL_PERF_EN
    chk("add_cyc", cyc_cnt, 4);
    chk("add_instr", instr_cnt, 1);
`endif

    // ROR: immediate ALU op
    opcode = 4'h6;
    step(); step();
    chk("ror_aluop", 32'(ALUOp), 6);
    chk("ror_alusrc", 32'(ALUsrc), 1);
    step();
    chk("ror_rw", 32'(RegWrite), 1);
    step();

    // LW with dmem_ack three cycles late
    opcode = 4'h8; dmem_ack = 0;
    step();
    chk("lw_rr", 32'(RegRead), 1);
    step();
    chk("lw_exec_aluop", 32'(ALUOp), 0);
    chk("lw_exec_alusrc", 32'(ALUsrc), 1);
    step();
    chk("lw_m1_state", 32'(state), 3);
    chk("lw_m1_mr", 32'(MemRead), 1);
    chk("lw_m1_rw", 32'(RegWrite), 0);
    chk("lw_m1_alusrc", 32'(ALUsrc), 1);
    step();
    chk("lw_m2_mr", 32'(MemRead), 1);
    step();
    chk("lw_m3_mr", 32'(MemRead), 1);
    chk("lw_m3_rw", 32'(RegWrite), 0);
    step();
    dmem_ack = 1; #1;
    chk("lw_m4_state", 32'(state), 3);
    chk("lw_m4_mr", 32'(MemRead), 1);
    step();
    chk("lw_wb_state", 32'(state), 4);
    chk("lw_wb_mtr", 32'(MemtoReg), 3);
    chk("lw_wb_rw", 32'(RegWrite), 1);
    chk("lw_wb_mr", 32'(MemRead), 0);
    step();

    // SW with one fetch wait state
    opcode = 4'h9; imem_ack = 0; #1;
    chk("sw_fwait_req", 32'(imem_req), 1);
    chk("sw_fwait_irw", 32'(IRWrite), 0);
    step();
    chk("sw_fwait_state", 32'(state), 0);
    imem_ack = 1; #1;
    chk("sw_fack_irw", 32'(IRWrite), 1);
    step(); step(); step();
    chk("sw_mem_mw", 32'(MemWrite), 1);
    chk("sw_mem_rw", 32'(RegWrite), 0);
    chk("sw_mem_pcw", 32'(PCWrite), 0);
    step();
    chk("sw_done_state", 32'(state), 0);
`ifdef CPU_MC_CONTROL_PERF_EN
    chk("sw_cyc", cyc_cnt, 21);
    chk("sw_instr", instr_cnt, 4);
`endif

    // LHB, PCS
    opcode = 4'hB;
    step();
    chk("lhb_rr", 32'(RegRead), 0);
    step();
    chk("lhb_state", 32'(state), 4);
    chk("lhb_mtr", 32'(MemtoReg), 1);
    chk("lhb_lh", 32'(LH), 1);
    step();
    opcode = 4'hE;
    step(); step();
    chk("pcs_mtr", 32'(MemtoReg), 0);
    chk("pcs_lh", 32'(LH), 0);
    step();

    // BR taken, then B not taken
    opcode = 4'hD; br_taken = 1;
    step();
    chk("br_rr", 32'(RegRead), 1);
    step();
    chk("br_state", 32'(state), 5);
    chk("br_pcs", 32'(PCSour), 1);
    chk("br_pcw", 32'(PCWrite), 1);
    step();
    opcode = 4'hC; br_taken = 0;
    step(); step();
    chk("b_pcs", 32'(PCSour), 3);
    chk("b_pcw", 32'(PCWrite), 0);
    step();
    chk("b_done_state", 32'(state), 0);

    // rst during SW MEM
    opcode = 4'h9; dmem_ack = 0;
    step(); step(); step();
    chk("swr_mw", 32'(MemWrite), 1);
    rst = 1; #1;
    chk("swr_rst_mw", 32'(MemWrite), 0);
    chk("swr_rst_state", 32'(state), 0);
    chk("swr_rst_req", 32'(imem_req), 0);
`ifdef CPU_MC_CONTROL_PERF_EN
    chk("swr_rst_cyc", cyc_cnt, 0);
    chk("swr_rst_instr", instr_cnt, 0);
`endif
    step();
    chk("swr_after_state", 32'(state), 0);
    rst = 0; dmem_ack = 1; #1;

    // HLT
    opcode = 4'hF;
    chk("hlt_c0_req", 32'(imem_req), 1);
    step(); step();
    chk("hlt_state", 32'(state), 6);
    chk("hlt_hlt", 32'(HLT), 1);
    for (int i = 0; i < 20; i++) begin
      step();
      chk("hlt_hold_req", 32'(imem_req), 0);
      chk("hlt_hold_hlt", 32'(HLT), 1);
    end
`ifdef CPU_MC_CONTROL_PERF_EN
    chk("hlt_cyc_frozen", cyc_cnt, 2);
    chk("hlt_instr", instr_cnt, 0);
`endif
    rst = 1;
    step();
    rst = 0; #1;
    chk("hlt_rel_state", 32'(state), 0);
    chk("hlt_rel_req", 32'(imem_req), 1);
    chk("hlt_rel_hlt", 32'(HLT), 0);

    // DUT B: fetch timeout after 4 unacked request cycles
    b_rst = 0; b_imem_ack = 0; #1;
    for (int i = 0; i < 4; i++) begin
      chk("to_req", 32'(b_imem_req), 1);
      chk("to_state", 32'(b_state), 0);
      chk("to_flag_early", 32'(b_mem_timeout), 0);
      step();
    end
    chk("to_state_halt", 32'(b_state), 6);
    chk("to_flag", 32'(b_mem_timeout), 1);
    chk("to_hlt", 32'(b_HLT), 1);
    chk("to_irw", 32'(b_IRWrite), 0);
    chk("to_req_off", 32'(b_imem_req), 0);

    // Ack arriving in the limit cycle wins
    b_rst = 1;
    step();
    b_rst = 0; b_opcode = 6'h00; #1;
    chk("aw_flag_clr", 32'(b_mem_timeout), 0);
    step(); step(); step();
    b_imem_ack = 1; #1;
    chk("aw_irw", 32'(b_IRWrite), 1);
    step();
    chk("aw_state", 32'(b_state), 1);
    chk("aw_flag", 32'(b_mem_timeout), 0);

    // Illegal wide opcode
    b_rst = 1;
    step();
    b_rst = 0; b_opcode = 6'h10; #1;
    step();
    chk("ill_dec_state", 32'(b_state), 1);
    chk("ill_rr", 32'(b_RegRead), 0);
    step();
    chk("ill_state", 32'(b_state), 6);
    chk("ill_flag", 32'(b_illegal_op), 1);
    chk("ill_hlt", 32'(b_HLT), 1);
    chk("ill_to", 32'(b_mem_timeout), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
